// File: rtl/jtkiwi_gfx_sdram.sv
// rtl/jtkiwi_gfx_sdram.sv - two-slot 32-bit graphics fetch cache in front of a 16-bit SDRAM port
module jtkiwi_gfx_sdram #(
  parameter logic [20:0] SCR_BASE = 21'h00000,
  parameter logic [20:0] OBJ_BASE = 21'h80000
) (
  input  logic        clk,
  input  logic        rst,
  // scroll slot
  input  logic        scr_cs,
  input  logic [19:2] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  // object slot
  input  logic        obj_cs,
  input  logic [19:2] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  // SDRAM read port
  output logic        sdram_req,
  output logic [21:1] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic        sdram_rdy,
  input  logic [15:0] sdram_din
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RECV     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [21:1] addr_q, addr_d;
  logic [19:2] fetch_tag_q, fetch_tag_d;
  logic        fetch_obj_q, fetch_obj_d;   // 1 when the fetch in flight belongs to the object slot
  logic        last_obj_q, last_obj_d;     // 1 when the object slot was served last
  logic [15:0] lo_q, lo_d;

  logic [19:2] scr_tag_q, scr_tag_d;
  logic [31:0] scr_word_q, scr_word_d;
  logic        scr_valid_q, scr_valid_d;
  logic [19:2] obj_tag_q, obj_tag_d;
  logic [31:0] obj_word_q, obj_word_d;
  logic        obj_valid_q, obj_valid_d;

  logic        scr_miss, obj_miss, sel_obj;

  // Hit detection is purely combinational so a hit costs no cycles.
  always_comb begin
    scr_ok   = scr_cs & scr_valid_q & (scr_addr == scr_tag_q);
    obj_ok   = obj_cs & obj_valid_q & (obj_addr == obj_tag_q);
    scr_miss = scr_cs & ~scr_ok;
    obj_miss = obj_cs & ~obj_ok;
    scr_data = scr_word_q;
    obj_data = obj_word_q;
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  // Fetch FSM: arbitrate a miss, hold the request until ack, gather two halves, commit.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    fetch_tag_d = fetch_tag_q;
    fetch_obj_d = fetch_obj_q;
    last_obj_d  = last_obj_q;
    lo_d        = lo_q;
    scr_tag_d   = scr_tag_q;
    scr_word_d  = scr_word_q;
    scr_valid_d = scr_valid_q;
    obj_tag_d   = obj_tag_q;
    obj_word_d  = obj_word_q;
    obj_valid_d = obj_valid_q;
    // With both slots missing, the one not served last wins.
    sel_obj     = obj_miss & (~scr_miss | ~last_obj_q);

    case (state_q)
      IDLE: begin
        if (scr_miss | obj_miss) begin
          fetch_obj_d = sel_obj;
          last_obj_d  = sel_obj;
          fetch_tag_d = sel_obj ? obj_addr : scr_addr;
          addr_d      = sel_obj ? ({2'b0, obj_addr, 1'b0} + OBJ_BASE)
                                : ({2'b0, scr_addr, 1'b0} + SCR_BASE);
          req_d       = 1'b1;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = RECV;
        end
      end
      RECV: begin
        // rdy coincides with the second strobe, so it marks the high half.
        if (sdram_rdy) begin
          if (fetch_obj_q) begin
            obj_tag_d   = fetch_tag_q;
            obj_word_d  = {sdram_din, lo_q};
            obj_valid_d = 1'b1;
          end else begin
            scr_tag_d   = fetch_tag_q;
            scr_word_d  = {sdram_din, lo_q};
            scr_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sdram_dst) begin
          lo_d = sdram_din;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any fetch and leaves scroll with priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      fetch_tag_q <= '0;
      fetch_obj_q <= 1'b0;
      last_obj_q  <= 1'b1;
      lo_q        <= '0;
      scr_tag_q   <= '0;
      scr_word_q  <= '0;
      scr_valid_q <= 1'b0;
      obj_tag_q   <= '0;
      obj_word_q  <= '0;
      obj_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      fetch_tag_q <= fetch_tag_d;
      fetch_obj_q <= fetch_obj_d;
      last_obj_q  <= last_obj_d;
      lo_q        <= lo_d;
      scr_tag_q   <= scr_tag_d;
      scr_word_q  <= scr_word_d;
      scr_valid_q <= scr_valid_d;
      obj_tag_q   <= obj_tag_d;
      obj_word_q  <= obj_word_d;
      obj_valid_q <= obj_valid_d;
    end
  end

endmodule
